otdr_echo_accumulator: RTL and testbench

- Receive-side partner of the pulse train generator.
- Each launch is marked by a rising edge of pulse_in. On that edge, the block captures a fixed-length record of ADC backscatter samples.
- Records from num_shots launches are summed, sample by sample, into an internal accumulation memory.
- Host logic reads the summed trace through a read port once done pulses.

---
 rtl/otdr_echo_accumulator.sv | 173 +++++++++++++++++
 tb/tb_otdr_echo_accumulator.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otdr_echo_accumulator.sv
// otdr_echo_accumulator
// Captures a fixed-length record of ADC samples after each rising edge of
// pulse_in and sums num_shots such records, sample by sample, into an
// internal memory. The summed trace is read back through a registered port.
module otdr_echo_accumulator #(
    parameter int ADC_W = 12,
    parameter int ACC_W = 20,
    parameter int DEPTH = 256
) (
    input  logic             clock,
    input  logic             reset_async,
    input  logic             pulse_in,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    input  logic             start,
    input  logic [7:0]       record_len,
    input  logic [7:0]       num_shots,
    input  logic [7:0]       rd_addr,
    output logic [ACC_W-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic [7:0]       shot_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t           state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       shots_q, shots_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       shot_cnt_d;
    logic             sat_d;
    logic             pulse_d;
    logic             trig;
    logic             mem_we;
    logic [ACC_W-1:0] mem_wdata;
    logic [ACC_W-1:0] rmw_word;
    logic [ACC_W:0]   rmw_sum;
    logic [ACC_W-1:0] mem [DEPTH];

    // Launch marker: only a fresh rising edge of pulse_in starts a shot.
    assign trig = pulse_in & ~pulse_d;

    // Read side of the read-modify-write: one extra bit catches overflow.
    assign rmw_word = mem[idx_q];
    assign rmw_sum  = {1'b0, rmw_word} + (ACC_W+1)'(adc_data);

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // Next-state and datapath control for the acquisition sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        len_d      = len_q;
        shots_d    = shots_q;
        idx_d      = idx_q;
        shot_cnt_d = shot_cnt;
        sat_d      = sat;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = record_len;
                    shots_d    = num_shots;
                    sat_d      = 1'b0;
                    shot_cnt_d = 8'd0;
                    idx_d      = 8'd0;
                    if (record_len == 8'd0 || num_shots == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end

            CLEAR: begin
                // Zero only the words this run will accumulate into.
                mem_we    = 1'b1;
                mem_wdata = '0;
                if (idx_q == len_q - 8'd1) begin
                    state_d = ARM;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end

            ARM: begin
                if (trig) begin
                    idx_d   = 8'd0;
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                // Triggers are ignored here; only valid samples advance idx.
                if (adc_valid) begin
                    mem_we = 1'b1;
                    if (rmw_sum[ACC_W]) begin
                        mem_wdata = ACC_MAX;
                        sat_d     = 1'b1;
                    end else begin
                        mem_wdata = rmw_sum[ACC_W-1:0];
                    end
                    idx_d = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        shot_cnt_d = shot_cnt + 8'd1;
                        if (shot_cnt + 8'd1 == shots_q) begin
                            state_d = DONE;
                        end else begin
                            state_d = ARM;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers, status outputs and the registered host read.
    always_ff @(posedge clock or negedge reset_async) begin
        if (!reset_async) begin
            state_q  <= IDLE;
            len_q    <= 8'd0;
            shots_q  <= 8'd0;
            idx_q    <= 8'd0;
            shot_cnt <= 8'd0;
            sat      <= 1'b0;
            pulse_d  <= 1'b0;
            rd_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            len_q    <= len_d;
            shots_q  <= shots_d;
            idx_q    <= idx_d;
            shot_cnt <= shot_cnt_d;
            sat      <= sat_d;
            pulse_d  <= pulse_in;
            rd_data  <= mem[rd_addr];
        end
    end

    // Accumulation memory write port (CLEAR zeroing and CAPTURE updates).
    always_ff @(posedge clock) begin
        // NOTE: the memory has no reset so it maps onto RAM; CLEAR
        // initialises exactly the words a run uses.
        if (mem_we) begin
            mem[idx_q] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_otdr_echo_accumulator.sv
// Bench for otdr_echo_accumulator: two instances (ACC_W=20 and ACC_W=13)
// share all inputs; expectations come from a per-address sum model.
module tb_otdr_echo_accumulator;

    localparam longint MAX20 = (64'd1 << 20) - 1;
    localparam longint MAX13 = (64'd1 << 13) - 1;

    // Per-cycle vectors for the trigger-timing scenario.
    localparam int TP [11] = '{1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 1};
    localparam int TV [11] = '{1, 1, 0, 0, 1, 1, 1, 1, 0, 1, 1};
    localparam int TD [11] = '{999, 1, 0, 0, 2, 500, 500, 500, 0, 1, 2};

    logic        clock;
    logic        reset_async;
    logic        pulse_in;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        start;
    logic [7:0]  record_len;
    logic [7:0]  num_shots;
    logic [7:0]  rd_addr;
    logic [19:0] rd_data;
    logic        busy, done, sat;
    logic [7:0]  shot_cnt;
    logic [12:0] rd_data_s;
    logic        busy_s, done_s, sat_s;
    logic [7:0]  shot_cnt_s;

    int tests_run = 0;
    int fails     = 0;
    int done_cnt  = 0;
    int done_cnt_s = 0;

    // Reference model: samples per shot, expected words, known flags.
    logic [11:0] smp [4][256];
    longint      exp20 [256];
    longint      exp13 [256];
    bit          known [256];
    bit          msat20, msat13;

    otdr_echo_accumulator dut (
        .clock(clock), .reset_async(reset_async), .pulse_in(pulse_in),
        .adc_data(adc_data), .adc_valid(adc_valid), .start(start),
        .record_len(record_len), .num_shots(num_shots), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .sat(sat),
        .shot_cnt(shot_cnt)
    );

    otdr_echo_accumulator #(.ACC_W(13)) dut_s (
        .clock(clock), .reset_async(reset_async), .pulse_in(pulse_in),
        .adc_data(adc_data), .adc_valid(adc_valid), .start(start),
        .record_len(record_len), .num_shots(num_shots), .rd_addr(rd_addr),
        .rd_data(rd_data_s), .busy(busy_s), .done(done_s), .sat(sat_s),
        .shot_cnt(shot_cnt_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
        if (done_s === 1'b1) done_cnt_s++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input int p, input int v, input int d);
        pulse_in  = 1'(p);
        adc_valid = 1'(v);
        adc_data  = 12'(d);
        step();
    endtask

    task automatic do_start(input int len, input int n, input int waitc);
        start = 1'b1; record_len = 8'(len); num_shots = 8'(n);
        step();
        start = 1'b0;
        record_len = 8'($urandom); num_shots = 8'($urandom);
        repeat (waitc) step();
    endtask

    // One shot: trigger edge, then len samples with optional gaps/noise.
    task automatic run_shot(input int s, input int len, input int gap, input bit noise);
        drv(1, noise ? int'($urandom_range(0, 1)) : 0, int'($urandom_range(0, 4095)));
        for (int i = 0; i < len; i++) begin
            int ng;
            ng = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
            repeat (ng) drv(noise ? int'($urandom_range(0, 1)) : 0, 0, int'($urandom_range(0, 4095)));
            drv((noise && i < len - 1) ? int'($urandom_range(0, 1)) : 0, 1, int'(smp[s][i]));
        end
        pulse_in = 1'b0; adc_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic read_word(input int a, output logic [19:0] d20, output logic [12:0] d13);
        rd_addr = 8'(a);
        step();
        d20 = rd_data;
        d13 = rd_data_s;
    endtask

    // Each word is the saturated sum of that sample position over all shots.
    task automatic model_apply(input int len, input int n);
        longint tot;
        msat20 = 1'b0; msat13 = 1'b0;
        for (int i = 0; i < len; i++) begin
            tot = 0;
            for (int s = 0; s < n; s++) tot += longint'(smp[s][i]);
            exp20[i] = (tot > MAX20) ? MAX20 : tot;
            exp13[i] = (tot > MAX13) ? MAX13 : tot;
            if (tot > MAX20) msat20 = 1'b1;
            if (tot > MAX13) msat13 = 1'b1;
            known[i] = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_async = 1'b1; pulse_in = 0; adc_valid = 0; adc_data = 0;
        start = 0; record_len = 0; num_shots = 0; rd_addr = 0;
        #1 reset_async = 1'b0;
        #2;
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++; if (sat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b want 0", sat); end
        tests_run++; if (shot_cnt !== 8'd0) begin fails++; $display("FAIL reset_shot_cnt: got %0d want 0", shot_cnt); end
        tests_run++; if (rd_data !== 20'd0) begin fails++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        step(); step();
        reset_async = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int dc0; bit ok; logic [19:0] r20; logic [12:0] r13;
        smp[0][0] = 10; smp[0][1] = 20; smp[0][2] = 30; smp[0][3] = 40;
        dc0 = done_cnt;
        do_start(4, 1, 3);
        drv(1, 0, 0);     // last CLEAR cycle: must be ignored
        drv(0, 1, 7);     // first ARM cycle, no edge: sample ignored
        drv(1, 1, 999);   // trigger cycle: sample not captured
        for (int i = 0; i < 4; i++) drv(0, 1, int'(smp[0][i]));
        adc_valid = 0;
        wait_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL basic_idle: busy stuck got %b want 0", busy); end
        model_apply(4, 1);
        for (int i = 0; i < 4; i++) begin
            read_word(i, r20, r13);
            tests_run++; if (r20 !== 20'(exp20[i])) begin fails++; $display("FAIL basic_mem[%0d]: got %0d want %0d", i, r20, exp20[i]); end
        end
        tests_run++; if (done_cnt !== dc0 + 1) begin fails++; $display("FAIL basic_done_count: got %0d want %0d", done_cnt - dc0, 1); end
        tests_run++; if (shot_cnt !== 8'd1) begin fails++; $display("FAIL basic_shot_cnt: got %0d want 1", shot_cnt); end
        tests_run++; if (shot_cnt_s !== 8'd1) begin fails++; $display("FAIL basic_shot_cnt_s: got %0d want 1", shot_cnt_s); end
        tests_run++; if (busy !== 1'b0 || busy_s !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b/%b want 0/0", busy, busy_s); end
        tests_run++; if (done_cnt_s !== done_cnt) begin fails++; $display("FAIL basic_done_s: got %0d want %0d", done_cnt_s, done_cnt); end
    endtask

    task automatic test_averaging();
        bit ok; logic [19:0] r20; logic [12:0] r13;
        for (int s = 0; s < 3; s++) begin
            smp[s][0] = 100; smp[s][1] = 200; smp[s][2] = 300;
        end
        do_start(3, 3, 3);
        run_shot(0, 3, 0, 1'b0);
        run_shot(1, 3, 2, 1'b0);   // trigger lands in the first ARM cycle
        run_shot(2, 3, 2, 1'b0);
        wait_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL avg_idle: busy stuck got %b want 0", busy); end
        model_apply(3, 3);
        for (int i = 0; i < 3; i++) begin
            read_word(i, r20, r13);
            tests_run++; if (r20 !== 20'(exp20[i])) begin fails++; $display("FAIL avg_mem[%0d]: got %0d want %0d", i, r20, exp20[i]); end
        end
        tests_run++; if (shot_cnt !== 8'd3) begin fails++; $display("FAIL avg_shot_cnt: got %0d want 3", shot_cnt); end
    endtask

    task automatic test_trigger_timing();
        int dc0; bit ok; logic [19:0] r20; logic [12:0] r13;
        dc0 = done_cnt;
        do_start(2, 2, 2);
        for (int c = 0; c < 11; c++) begin
            drv(TP[c], TV[c], TD[c]);
            if (c == 4 || c == 7) begin
                tests_run++; if (shot_cnt !== 8'd1 || busy !== 1'b1) begin
                    fails++; $display("FAIL trig_mid_shot_cnt c%0d: got %0d busy %b want 1 busy 1", c, shot_cnt, busy);
                end
            end
        end
        pulse_in = 0; adc_valid = 0;
        wait_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL trig_idle: busy stuck got %b want 0", busy); end
        smp[0][0] = 1; smp[0][1] = 2; smp[1][0] = 1; smp[1][1] = 2;
        model_apply(2, 2);
        for (int i = 0; i < 2; i++) begin
            read_word(i, r20, r13);
            tests_run++; if (r20 !== 20'(exp20[i])) begin fails++; $display("FAIL trig_mem[%0d]: got %0d want %0d", i, r20, exp20[i]); end
        end
        tests_run++; if (shot_cnt !== 8'd2) begin fails++; $display("FAIL trig_shot_cnt: got %0d want 2", shot_cnt); end
        tests_run++; if (done_cnt !== dc0 + 1) begin fails++; $display("FAIL trig_done_count: got %0d want 1", done_cnt - dc0); end
    endtask

    task automatic test_saturation();
        bit ok; logic [19:0] r20; logic [12:0] r13;
        for (int s = 0; s < 3; s++) smp[s][0] = 12'd4095;
        do_start(1, 3, 1);
        for (int s = 0; s < 3; s++) run_shot(s, 1, 0, 1'b0);
        wait_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL sat_idle: busy stuck got %b want 0", busy); end
        model_apply(1, 3);
        read_word(0, r20, r13);
        tests_run++; if (r13 !== 13'(exp13[0])) begin fails++; $display("FAIL sat_mem13: got %0d want %0d", r13, exp13[0]); end
        tests_run++; if (r20 !== 20'(exp20[0])) begin fails++; $display("FAIL sat_mem20: got %0d want %0d", r20, exp20[0]); end
        tests_run++; if (sat_s !== msat13) begin fails++; $display("FAIL sat_flag13: got %b want %b", sat_s, msat13); end
        tests_run++; if (sat !== msat20) begin fails++; $display("FAIL sat_flag20: got %b want %b", sat, msat20); end
        smp[0][0] = 1; smp[1][0] = 1;
        do_start(1, 2, 1);
        tests_run++; if (sat_s !== 1'b0) begin fails++; $display("FAIL sat_clear_on_start: got %b want 0", sat_s); end
        run_shot(0, 1, 0, 1'b0);
        run_shot(1, 1, 0, 1'b0);
        wait_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL sat2_idle: busy stuck got %b want 0", busy); end
        model_apply(1, 2);
        read_word(0, r20, r13);
        tests_run++; if (r13 !== 13'(exp13[0])) begin fails++; $display("FAIL sat2_mem13: got %0d want %0d", r13, exp13[0]); end
        tests_run++; if (r20 !== 20'(exp20[0])) begin fails++; $display("FAIL sat2_mem20: got %0d want %0d", r20, exp20[0]); end
        tests_run++; if (sat_s !== 1'b0) begin fails++; $display("FAIL sat2_flag13: got %b want 0", sat_s); end
    endtask

    task automatic test_degenerate();
        int dc0; bit ok; logic [19:0] r20; logic [12:0] r13;
        for (int k = 0; k < 2; k++) begin
            dc0 = done_cnt;
            start = 1'b1; record_len = (k == 0) ? 8'd0 : 8'd5; num_shots = (k == 0) ? 8'd3 : 8'd0;
            step();
            start = 1'b0;
            tests_run++; if (done !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL degen%0d_done_next: got done %b busy %b want 1 1", k, done, busy); end
            step();
            tests_run++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL degen%0d_idle: got done %b busy %b want 0 0", k, done, busy); end
            tests_run++; if (done_cnt !== dc0 + 1 || shot_cnt !== 8'd0) begin fails++; $display("FAIL degen%0d_count: got done %0d shots %0d want 1 0", k, done_cnt - dc0, shot_cnt); end
        end
        for (int i = 0; i < 5; i++) begin
            if (known[i]) begin
                read_word(i, r20, r13);
                tests_run++; if (r20 !== 20'(exp20[i])) begin fails++; $display("FAIL degen_nowrite[%0d]: got %0d want %0d", i, r20, exp20[i]); end
            end
        end
        // A start pulse in the middle of CAPTURE must not disturb the run.
        for (int i = 0; i < 3; i++) smp[0][i] = 12'($urandom);
        dc0 = done_cnt;
        do_start(3, 1, 3);
        drv(1, 0, 0);
        drv(0, 1, int'(smp[0][0]));
        start = 1'b1; record_len = 8'd1; num_shots = 8'd1;
        drv(0, 0, 0);
        start = 1'b0;
        drv(0, 1, int'(smp[0][1]));
        drv(0, 1, int'(smp[0][2]));
        adc_valid = 0;
        wait_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL busy_start_idle: busy stuck got %b want 0", busy); end
        model_apply(3, 1);
        for (int i = 0; i < 3; i++) begin
            read_word(i, r20, r13);
            tests_run++; if (r20 !== 20'(exp20[i])) begin fails++; $display("FAIL busy_start_mem[%0d]: got %0d want %0d", i, r20, exp20[i]); end
        end
        tests_run++; if (shot_cnt !== 8'd1 || done_cnt !== dc0 + 1) begin fails++; $display("FAIL busy_start_count: got shots %0d done %0d want 1 1", shot_cnt, done_cnt - dc0); end
    endtask

    task automatic test_reset_mid();
        int dc0; bit ok; logic [19:0] r20; logic [12:0] r13;
        for (int s = 0; s < 4; s++) for (int i = 0; i < 3; i++) smp[s][i] = 12'($urandom);
        do_start(3, 4, 3);
        run_shot(0, 3, 0, 1'b0);
        drv(1, 0, 0);
        drv(0, 1, int'(smp[1][0]));
        dc0 = done_cnt;
        reset_async = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || shot_cnt !== 8'd0 || sat !== 1'b0) begin
            fails++; $display("FAIL rst_mid_async: got busy %b shots %0d sat %b want 0 0 0", busy, shot_cnt, sat);
        end
        tests_run++; if (rd_data !== 20'd0 || busy_s !== 1'b0) begin fails++; $display("FAIL rst_mid_rd: got %0d busy_s %b want 0 0", rd_data, busy_s); end
        @(posedge clock); #1;
        reset_async = 1'b1;
        repeat (4) step();
        tests_run++; if (done_cnt !== dc0 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_nodone: got done %0d busy %b want 0 0", done_cnt - dc0, busy); end
        for (int s = 0; s < 2; s++) for (int i = 0; i < 3; i++) smp[s][i] = 12'($urandom);
        do_start(3, 2, 3);
        run_shot(0, 3, -1, 1'b0);
        run_shot(1, 3, -1, 1'b0);
        wait_idle(ok);
        tests_run++; if (!ok) begin fails++; $display("FAIL rst_rerun_idle: busy stuck got %b want 0", busy); end
        model_apply(3, 2);
        for (int i = 0; i < 3; i++) begin
            read_word(i, r20, r13);
            tests_run++; if (r20 !== 20'(exp20[i])) begin fails++; $display("FAIL rst_rerun_mem[%0d]: got %0d want %0d", i, r20, exp20[i]); end
        end
        tests_run++; if (shot_cnt !== 8'd2 || done_cnt !== dc0 + 1) begin fails++; $display("FAIL rst_rerun_count: got shots %0d done %0d want 2 1", shot_cnt, done_cnt - dc0); end
    endtask

    task automatic test_random();
        int len, n, dc0; bit ok, had_next; longint next20;
        logic [19:0] r20; logic [12:0] r13;
        for (int run = 0; run < 6; run++) begin
            len = int'($urandom_range(1, 24));
            n   = int'($urandom_range(1, 4));
            for (int s = 0; s < n; s++) for (int i = 0; i < len; i++) smp[s][i] = 12'($urandom);
            had_next = known[len];
            next20   = exp20[len];
            dc0 = done_cnt;
            do_start(len, n, len);
            for (int s = 0; s < n; s++) run_shot(s, len, -1, 1'b1);
            wait_idle(ok);
            tests_run++; if (!ok) begin fails++; $display("FAIL rnd%0d_idle: busy stuck got %b want 0", run, busy); end
            model_apply(len, n);
            for (int i = 0; i < len; i++) begin
                read_word(i, r20, r13);
                tests_run++; if (r20 !== 20'(exp20[i])) begin fails++; $display("FAIL rnd%0d_mem20[%0d]: got %0d want %0d", run, i, r20, exp20[i]); end
                tests_run++; if (r13 !== 13'(exp13[i])) begin fails++; $display("FAIL rnd%0d_mem13[%0d]: got %0d want %0d", run, i, r13, exp13[i]); end
            end
            if (had_next) begin
                read_word(len, r20, r13);
                tests_run++; if (r20 !== 20'(next20)) begin fails++; $display("FAIL rnd%0d_untouched[%0d]: got %0d want %0d", run, len, r20, next20); end
            end
            tests_run++; if (sat !== msat20 || sat_s !== msat13) begin fails++; $display("FAIL rnd%0d_sat: got %b/%b want %b/%b", run, sat, sat_s, msat20, msat13); end
            tests_run++; if (shot_cnt !== 8'(n) || done_cnt !== dc0 + 1) begin fails++; $display("FAIL rnd%0d_count: got shots %0d done %0d want %0d 1", run, shot_cnt, done_cnt - dc0, n); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            known[i] = 1'b0; exp20[i] = 0; exp13[i] = 0;
        end
        test_reset();
        test_basic();
        test_averaging();
        test_trigger_timing();
        test_saturation();
        test_degenerate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
